mdu_ctrl: RTL and testbench

- Multiply/divide unit controller for the EX stage.
- Owns the architectural HI/LO register and accepts MTHI/MTLO writes.
- Sequences MULT/MULTU through a registered multiply and DIV/DIVU through an iterative radix-2 divider.
- Drives a stall to the pipeline until the result is committed to HI/LO. The ALU reads HI/LO for MFHI/MFLO from hilo_o.

---
 rtl/mdu_ctrl_pkg.sv | 24 ++
 rtl/mdu_ctrl_div_radix2.sv | 60 ++++++
 rtl/mdu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared op codes, FSM encoding and helpers for the multiply/divide controller.
// The EXE_*_OP values match the EX-stage op codes the decoder emits.
package mdu_ctrl_pkg;

  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // Magnitude of v when treated as signed; 0x8000_0000 maps to itself (read as unsigned).
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_radix2.sv
// Iterative unsigned radix-2 divider: one quotient bit per clock on a {rem,quot} register.
// done is high during the final iteration, so quot/rem are final on the following cycle.
module div_radix2 #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        done
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  logic [63:0]      rq_reg;
  logic [31:0]      divisor_reg;
  logic [CNT_W-1:0] count_reg;
  logic             active_reg;

  logic [32:0] partial;
  logic [32:0] diff;
  logic        take;
  logic        last;

  // partial can reach 33 bits, so a set bit 32 means it already exceeds any divisor.
  always_comb begin
    partial = rq_reg[63:31];
    diff    = partial - {1'b0, divisor_reg};
    take    = partial[32] | ~diff[32];
    last    = active_reg && (count_reg == CNT_W'(DIV_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rq_reg      <= '0;
      divisor_reg <= '0;
      count_reg   <= '0;
      active_reg  <= 1'b0;
    end else if (start) begin
      rq_reg      <= {32'd0, dividend};
      divisor_reg <= divisor;
      count_reg   <= '0;
      active_reg  <= 1'b1;
    end else if (active_reg) begin
      rq_reg    <= {(take ? diff[31:0] : partial[31:0]), rq_reg[30:0], take};
      count_reg <= count_reg + CNT_W'(1);
      if (last) begin
        active_reg <= 1'b0;
      end
    end
  end

  assign quot = rq_reg[31:0];
  assign rem  = rq_reg[63:32];
  assign done = last;

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide controller: owns HI/LO, sequences MULT/DIV, stalls the pipe.
// Results land in HI/LO on the edge leaving DONE; flush abandons any operation without a write.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [7:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall_o,
  output logic        busy,
  output logic [63:0] hilo_o
);

  mdu_state_e state_reg, state_next;
  logic [63:0] hilo_reg, hilo_next;

  logic [31:0] mul_a_reg, mul_b_reg;
  logic        mul_signed_reg;
  logic        is_div_reg;
  logic        q_neg_reg, r_neg_reg;
  logic [63:0] result_reg;

  logic        accept;
  logic        div_signed;
  logic        latch_mul, latch_div, latch_dz, load_product, div_start;
  logic [63:0] ext_a, ext_b, product;
  logic [31:0] div_quot, div_rem, quot_fix, rem_fix;
  logic        div_done;

  // Gating with resetn keeps stall_o low while reset is held, even with an op still presented.
  assign accept     = op_valid & ~flush & resetn;
  assign div_signed = (op == EXE_DIV_OP);

  div_radix2 #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_start),
    .dividend (mag32(a, div_signed)),
    .divisor  (mag32(b, div_signed)),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  always_comb begin
    ext_a    = mul_signed_reg ? {{32{mul_a_reg[31]}}, mul_a_reg} : {32'd0, mul_a_reg};
    ext_b    = mul_signed_reg ? {{32{mul_b_reg[31]}}, mul_b_reg} : {32'd0, mul_b_reg};
    product  = ext_a * ext_b;
    quot_fix = q_neg_reg ? (~div_quot + 32'd1) : div_quot;
    rem_fix  = r_neg_reg ? (~div_rem + 32'd1) : div_rem;
  end

  always_comb begin
    state_next   = state_reg;
    hilo_next    = hilo_reg;
    stall_o      = 1'b0;
    latch_mul    = 1'b0;
    latch_div    = 1'b0;
    latch_dz     = 1'b0;
    load_product = 1'b0;
    div_start    = 1'b0;
    case (state_reg)
      MDU_IDLE: begin
        if (accept) begin
          case (op)
            EXE_MTHI_OP: hilo_next[63:32] = a;
            EXE_MTLO_OP: hilo_next[31:0]  = a;
            EXE_MULT_OP, EXE_MULTU_OP: begin
              stall_o    = 1'b1;
              latch_mul  = 1'b1;
              state_next = MDU_MUL;
            end
            EXE_DIV_OP, EXE_DIVU_OP: begin
              stall_o = 1'b1;
              if (b != 32'd0) begin
                latch_div  = 1'b1;
                div_start  = 1'b1;
                state_next = MDU_DIV;
              end else begin
                latch_dz   = 1'b1;
                state_next = MDU_DONE;
              end
            end
            default: ;
          endcase
        end
      end
      MDU_MUL: begin
        stall_o      = 1'b1;
        load_product = 1'b1;
        state_next   = MDU_DONE;
      end
      MDU_DIV: begin
        stall_o = 1'b1;
        if (div_done) begin
          state_next = MDU_DONE;
        end
      end
      MDU_DONE: begin
        hilo_next  = is_div_reg ? {rem_fix, quot_fix} : result_reg;
        state_next = MDU_IDLE;
      end
      default: state_next = MDU_IDLE;
    endcase
    if (flush) begin
      state_next = MDU_IDLE;
      hilo_next  = hilo_reg;
      stall_o    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= MDU_IDLE;
      hilo_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hilo_reg  <= hilo_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_a_reg      <= '0;
      mul_b_reg      <= '0;
      mul_signed_reg <= 1'b0;
      is_div_reg     <= 1'b0;
      q_neg_reg      <= 1'b0;
      r_neg_reg      <= 1'b0;
      result_reg     <= '0;
    end else begin
      if (latch_mul) begin
        mul_a_reg      <= a;
        mul_b_reg      <= b;
        mul_signed_reg <= (op == EXE_MULT_OP);
        is_div_reg     <= 1'b0;
      end
      if (latch_div) begin
        is_div_reg <= 1'b1;
        q_neg_reg  <= div_signed & (a[31] ^ b[31]);
        r_neg_reg  <= div_signed & a[31];
      end
      // Divide by zero skips the divider and reuses the product path to HI/LO.
      if (latch_dz) begin
        is_div_reg <= 1'b0;
        result_reg <= {a, 32'hFFFF_FFFF};
      end
      if (load_product) begin
        result_reg <= product;
      end
    end
  end

  assign busy   = (state_reg != MDU_IDLE);
  assign hilo_o = hilo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: arithmetic model of HI/LO and per-op stall/busy timeline,
// compared every cycle on the falling edge, plus literal expectations after key ops.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int DIV_CYCLES = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic [7:0]  op = 8'h00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        stall_o;
  logic        busy;
  logic [63:0] hilo_o;

  int checks = 0;
  int failures = 0;

  logic        exp_stall = 1'b0;
  logic        exp_busy = 1'b0;
  logic [63:0] exp_hilo = 64'd0;
  logic [63:0] model_hilo = 64'd0;
  bit          check_en = 1'b0;

  always #5 clk = ~clk;

  mdu_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .stall_o  (stall_o),
    .busy     (busy),
    .hilo_o   (hilo_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("stall_o", 64'(stall_o), 64'(exp_stall));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("hilo_o", hilo_o, exp_hilo);
    end
  end

  // Architectural result and cycles-in-EX of one op, straight from the arithmetic rules.
  function automatic void model(input logic [7:0] o, input logic [31:0] av, input logic [31:0] bv,
                                input logic [63:0] cur, output int lat, output logic [63:0] res);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    res = cur;
    lat = 1;
    case (o)
      EXE_MTHI_OP:  res = {av, cur[31:0]};
      EXE_MTLO_OP:  res = {cur[63:32], av};
      EXE_MULT_OP:  begin lat = 3; res = sa * sb; end
      EXE_MULTU_OP: begin lat = 3; res = ua * ub; end
      EXE_DIV_OP, EXE_DIVU_OP: begin
        if (bv == 32'd0) begin
          lat = 2;
          res = {av, 32'hFFFF_FFFF};
        end else begin
          lat = DIV_CYCLES + 2;
          if (o == EXE_DIV_OP) begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
          end else begin
            uq = ua / ub;
            ur = ua % ub;
            res = {ur[31:0], uq[31:0]};
          end
        end
      end
      default: ;
    endcase
  endfunction

  // kill_at: cycle index within the op at which flush (or reset, if kill_rst) is applied; -1 for none.
  task automatic run_op(input string tag, input logic [7:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int kill_at, input bit kill_rst);
    int lat;
    logic [63:0] res;
    bit killed;
    killed = 1'b0;
    model(o, av, bv, model_hilo, lat, res);
    for (int k = 0; k < lat; k++) begin
      op_valid = 1'b1;
      op = o;
      a = av;
      b = bv;
      killed = (k == kill_at);
      flush = killed && !kill_rst;
      if (killed && kill_rst) begin
        resetn = 1'b0;
        model_hilo = 64'd0;
      end
      exp_hilo = model_hilo;
      exp_stall = !killed && (k < lat - 1);
      exp_busy = !(killed && kill_rst) && (k > 0);
      @(posedge clk);
      #1;
      if (killed) break;
    end
    if (!killed) model_hilo = res;
    op_valid = 1'b0;
    flush = 1'b0;
    $display("op %-10s a=%h b=%h cycles=%0d killed=%0d hilo_model=%h", tag, av, bv, lat, killed, model_hilo);
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    flush = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_stall = 1'b0;
      exp_busy = 1'b0;
      exp_hilo = model_hilo;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0]  o;
    logic [31:0] av;
    logic [31:0] bv;
  } vec_t;

  vec_t extra[6];

  initial begin
    extra[0] = '{EXE_DIVU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    extra[1] = '{EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h8000_0001};
    extra[2] = '{EXE_DIV_OP,  32'd100,       32'hFFFF_FFF9};
    extra[3] = '{EXE_MULT_OP, 32'h8000_0000, 32'h8000_0000};
    extra[4] = '{EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    extra[5] = '{8'h00,       32'hDEAD_BEEF, 32'h1};

    check_en = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    idle(2);

    run_op("MULT", EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3, -1, 1'b0);
    idle(1);
    chk("lit_mult", hilo_o, 64'hFFFF_FFFF_FFFF_FFFA);

    run_op("MULTU", EXE_MULTU_OP, 32'hFFFF_FFFE, 32'd3, -1, 1'b0);
    idle(1);
    chk("lit_multu", hilo_o, 64'h0000_0002_FFFF_FFFA);

    run_op("DIV", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    idle(1);
    chk("lit_div_neg", hilo_o, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op("DIVU", EXE_DIVU_OP, 32'd100, 32'd7, -1, 1'b0);
    idle(1);
    chk("lit_divu", hilo_o, 64'h0000_0002_0000_000E);

    run_op("DIV_OVF", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    idle(1);
    chk("lit_div_ovf", hilo_o, 64'h0000_0000_8000_0000);

    run_op("DIV_ZERO", EXE_DIV_OP, 32'd5, 32'd0, -1, 1'b0);
    idle(1);
    chk("lit_div_zero", hilo_o, 64'h0000_0005_FFFF_FFFF);

    run_op("MTHI", EXE_MTHI_OP, 32'h1234_5678, 32'd0, -1, 1'b0);
    run_op("MTLO", EXE_MTLO_OP, 32'h9ABC_DEF0, 32'd0, -1, 1'b0);
    idle(1);
    chk("lit_mt", hilo_o, 64'h1234_5678_9ABC_DEF0);

    run_op("DIV_FLUSH", EXE_DIV_OP, 32'd1000, 32'd3, 11, 1'b0);
    idle(2);
    chk("lit_div_flush", hilo_o, 64'h1234_5678_9ABC_DEF0);

    run_op("DIVU_AGAIN", EXE_DIVU_OP, 32'd100, 32'd7, -1, 1'b0);
    idle(1);
    chk("lit_divu_again", hilo_o, 64'h0000_0002_0000_000E);

    run_op("MTHI_FLUSH", EXE_MTHI_OP, 32'hCAFE_F00D, 32'd0, 0, 1'b0);
    idle(1);
    chk("lit_mthi_flush", hilo_o, 64'h0000_0002_0000_000E);

    for (int i = 0; i < 6; i++) begin
      run_op("EXTRA", extra[i].o, extra[i].av, extra[i].bv, -1, 1'b0);
      idle(1);
    end

    run_op("MTHI", EXE_MTHI_OP, 32'hAAAA_5555, 32'd0, -1, 1'b0);
    idle(1);
    run_op("DIV_RESET", EXE_DIV_OP, 32'd77, 32'd5, 6, 1'b1);
    idle(2);
    chk("lit_reset_hilo", hilo_o, 64'd0);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
